// File: rtl/if_id_buffer.sv
// IF/ID decoupling FIFO: buffers fetched {pc, instruction} words between IF and ID.
// Optional macro IF_ID_BUFFER_BYPASS_EN forwards an incoming word straight to ID when empty.
module if_id_buffer #(
   parameter int unsigned WORD_WIDTH = 32,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic [WORD_WIDTH-1:0]   pc_in,
   input  logic [WORD_WIDTH-1:0]   instruction_in,
   input  logic                    flush,
   input  logic                    hazard_stall,
   output logic                    freeze,
   output logic                    out_valid,
   output logic [WORD_WIDTH-1:0]   pc,
   output logic [WORD_WIDTH-1:0]   instruction,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WORD_WIDTH-1:0] pc_mem_q    [DEPTH];
   logic [WORD_WIDTH-1:0] instr_mem_q [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             empty, full, push, pop, bypass_take;

   // Head decode, accept/consume handshakes and next pointer/count state
   always_comb begin
      empty       = (count_q == '0);
      full        = (count_q == CNT_W'(DEPTH));
      bypass_take = 1'b0;
      freeze      = full;
      out_valid   = !empty;
      pc          = empty ? '0 : pc_mem_q[rd_ptr_q];
      instruction = empty ? '0 : instr_mem_q[rd_ptr_q];
`ifdef IF_ID_BUFFER_BYPASS_EN
      // Empty buffer: present the incoming word directly; ID consumes it unless stalled
      if (empty && in_valid && !flush) begin
         out_valid   = 1'b1;
         pc          = pc_in;
         instruction = instruction_in;
         bypass_take = !hazard_stall;
      end
`endif
      push     = in_valid && !full && !flush && !bypass_take;
      pop      = !empty && !hazard_stall && !flush;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   assign count = count_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is never cleared; only pointers and count define what is live
   always_ff @(posedge clk) begin
      if (rst && push) begin
         pc_mem_q[wr_ptr_q]    <= pc_in;
         instr_mem_q[wr_ptr_q] <= instruction_in;
      end
   end

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer: driver queues expected words, a negedge monitor
// pops and compares every word ID consumes. Honours IF_ID_BUFFER_BYPASS_EN if defined.
module tb_if_id_buffer;

   localparam int unsigned W     = 32;
   localparam int unsigned DEPTH = 4;
`ifdef IF_ID_BUFFER_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic [W-1:0]  pc_in;
   logic [W-1:0]  instruction_in;
   logic          flush;
   logic          hazard_stall;
   logic          freeze;
   logic          out_valid;
   logic [W-1:0]  pc;
   logic [W-1:0]  instruction;
   logic [$clog2(DEPTH):0] count;

   if_id_buffer #(.WORD_WIDTH(W), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .pc_in          (pc_in),
      .instruction_in (instruction_in),
      .flush          (flush),
      .hazard_stall   (hazard_stall),
      .freeze         (freeze),
      .out_valid      (out_valid),
      .pc             (pc),
      .instruction    (instruction),
      .count          (count)
   );

   logic [2*W-1:0] exp_q [$];
   int n_cmp = 0;
   int n_err = 0;
   int mcnt  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] instr_of(input logic [W-1:0] p);
      return (p << 8) | 32'h0000_0013;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // One cycle of stimulus; the expected queue and occupancy follow the buffer's rules
   task automatic step(input logic iv, input logic [W-1:0] p, input logic fl,
                       input logic hs, input logic r);
      logic full, take, psh, pp;
      in_valid       = iv;
      pc_in          = p;
      instruction_in = instr_of(p);
      flush          = fl;
      hazard_stall   = hs;
      rst            = r;
      full = (mcnt == DEPTH);
      take = BYP && (mcnt == 0) && iv && !fl && !hs;
      psh  = iv && !full && !fl && !take;
      pp   = (mcnt != 0) && !hs && !fl;
      if (!r || fl) begin
         exp_q.delete();
         mcnt = 0;
      end else begin
         if (psh || take) exp_q.push_back({p, instr_of(p)});
         mcnt = mcnt + int'(psh) - int'(pp);
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: every word ID takes must be the oldest expected word
   initial begin
      logic [2*W-1:0] e;
      forever begin
         @(negedge clk);
         if (rst && out_valid && !hazard_stall && !flush) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_word: got pc %0h, want no word", pc);
            end else begin
               e = exp_q.pop_front();
               chk("sb_pc", pc, e[2*W-1:W]);
               chk("sb_instr", instruction, e[W-1:0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      in_valid = 0; pc_in = '0; instruction_in = '0;
      flush = 0; hazard_stall = 0; rst = 0;

      // Reset for two cycles
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_freeze", 32'(freeze), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_pc", pc, 0);
      chk("rst_instr", instruction, 0);

      // Fill under stall, then offer a fifth word while full
      for (int i = 1; i <= 4; i++) begin
         step(1, W'(4 * i), 0, 1, 1);
         chk("fill_count", 32'(count), 32'(i));
      end
      chk("fill_freeze", 32'(freeze), 1);
      chk("fill_head_pc", pc, 4);
      step(1, 20, 0, 1, 1);
      chk("full_count", 32'(count), 4);

      // Drain: 4, 8, 12, 16 then empty NOP
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
      chk("drain_count", 32'(count), 0);
      chk("drain_out_valid", 32'(out_valid), 0);
      chk("drain_pc", pc, 0);
      chk("drain_instr", instruction, 0);

      // Streaming one word per cycle
      for (int i = 0; i < 6; i++) begin
         step(1, W'(300 + 4 * i), 0, 0, 1);
         chk("stream_count", 32'(count), BYP ? 0 : 1);
         chk("stream_freeze", 32'(freeze), 0);
      end
      step(0, 0, 0, 0, 1);
      chk("stream_end_count", 32'(count), 0);

      // Flush with count 3 and a coincident word pc 40
      for (int i = 0; i < 3; i++) step(1, W'(500 + 4 * i), 0, 1, 1);
      chk("preflush_count", 32'(count), 3);
      step(1, 40, 1, 0, 1);
      chk("flush_count", 32'(count), 0);
      chk("flush_out_valid", 32'(out_valid), 0);
      chk("flush_freeze", 32'(freeze), 0);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);

      // Full with a pop and an offered word: only the pop happens
      for (int i = 0; i < 4; i++) step(1, W'(100 + 4 * i), 0, 1, 1);
      step(1, 200, 0, 0, 1);
      chk("full_pop_count", 32'(count), 3);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);

      // Full then flush: freeze drops the cycle after
      for (int i = 0; i < 4; i++) step(1, W'(400 + 4 * i), 0, 1, 1);
      chk("full_again_freeze", 32'(freeze), 1);
      step(1, 44, 1, 1, 1);
      chk("post_flush_freeze", 32'(freeze), 0);
      step(0, 0, 0, 0, 1);

      // Wrap-around with alternating stalls
      for (int i = 0; i < 2 * DEPTH + 1; i++) step(1, W'(600 + 4 * i), 0, 1'(i % 2), 1);
      for (int k = 0; k < 2 * DEPTH && mcnt != 0; k++) step(0, 0, 0, 0, 1);
      chk("wrap_count", 32'(count), 0);

      // Reset mid-operation coincident with push and flush
      step(1, 800, 0, 1, 1);
      step(1, 804, 0, 1, 1);
      chk("premid_count", 32'(count), 2);
      step(1, 700, 1, 0, 0);
      chk("midrst_count", 32'(count), 0);
      chk("midrst_freeze", 32'(freeze), 0);
      chk("midrst_out_valid", 32'(out_valid), 0);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);

      chk("sb_drained", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/if_id_buffer.md
IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 Parameter WORD_WIDTH, default 32, sets the width of the PC and instruction words.
REQ-002 Parameter DEPTH, default 4, sets the FIFO entry count; legal values are powers of two from 2 to 16.
REQ-003 Port clk, input, 1 bit: sole clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port in_valid, input, 1 bit: IF stage presents a fetched word this cycle.
REQ-006 Port pc_in, input, WORD_WIDTH bits: IF stage PC+4 value.
REQ-007 Port instruction_in, input, WORD_WIDTH bits: IF stage fetched instruction.
REQ-008 Port flush, input, 1 bit: branch_taken from EXE; discards all buffered and incoming words.
REQ-009 Port hazard_stall, input, 1 bit: ID stage cannot accept a word this cycle.
REQ-010 Port freeze, output, 1 bit: drives the IF stage freeze input; high means no word is accepted.
REQ-011 Port out_valid, output, 1 bit: pc/instruction hold a valid word for ID.
REQ-012 Port pc, output, WORD_WIDTH bits: head-entry PC to ID.
REQ-013 Port instruction, output, WORD_WIDTH bits: head-entry instruction to ID.
REQ-014 Port count, output, clog2(DEPTH)+1 bits: number of occupied entries.

Function
REQ-015 Storage is a circular FIFO of DEPTH {pc, instruction} entries with registered write pointer, read pointer and count; pointers wrap from DEPTH-1 to 0.
REQ-016 freeze = (count == DEPTH), decoded combinationally from the registered count only.
REQ-017 Push = in_valid && !freeze && !flush; a push writes pc_in/instruction_in at the write pointer and advances it.
REQ-018 Pop = out_valid && !hazard_stall && !flush; a pop advances the read pointer.
REQ-019 count next = count + push - pop; a simultaneous push and pop leaves count unchanged.
REQ-020 When full, a pop and an offered word in the same cycle pop only; the word is not accepted, because freeze was high.
REQ-021 out_valid = (count != 0); pc and instruction show the head entry combinationally; when empty, pc = 0 and instruction = 0 (NOP).
REQ-022 Push-to-visible latency is 1 cycle: a word pushed at edge N is at the head after edge N if the FIFO was empty.
REQ-023 Flush has priority over everything: on the next edge count, write pointer and read pointer become 0, and the in_valid word of the flush cycle is dropped.
REQ-024 freeze may be high in a flush cycle; it is low the cycle after the flush.
REQ-025 Stored contents are not cleared by flush or reset; only pointers and count are.
REQ-026 hazard_stall while empty has no effect.

Reset
REQ-027 On a rising edge with rst == 0: count, write pointer and read pointer become 0. As a result freeze = 0, out_valid = 0, pc = 0 and instruction = 0.
REQ-028 Reset overrides flush, push and pop in the same cycle; reset mid-stream discards all buffered words.

Configuration
REQ-029 Macro IF_ID_BUFFER_BYPASS_EN defined: when count == 0, in_valid == 1 and flush == 0, out_valid = 1 and pc/instruction = pc_in/instruction_in combinationally.
REQ-030 In that bypass case: if hazard_stall == 0, the word is consumed by ID and not written (count stays 0); if hazard_stall == 1, it is pushed normally.
REQ-031 Macro undefined: no combinational input-to-output path exists; REQ-021/REQ-022 apply unmodified.

Verification
REQ-032 Reset then fill: rst = 0 for 2 cycles, then words pc = 4, 8, 12, 16 with hazard_stall = 1 -> count goes 1..4, and freeze = 1 after the 4th edge; a 5th word pc = 20 offered while full is not stored.
REQ-033 Drain: from full (pc 4..16), hazard_stall = 0 and in_valid = 0 -> pc outputs are 4, 8, 12, 16 on consecutive cycles, then out_valid = 0 with pc = 0 and instruction = 0.
REQ-034 Streaming: continuous in_valid with hazard_stall = 0 -> count stays 1 (0 with BYPASS_EN), with one word per cycle and no freeze.
REQ-035 Flush: count = 3, flush = 1 together with in_valid (pc = 40) -> next cycle count = 0, out_valid = 0, and pc = 40 is never output.
REQ-036 Wrap-around: push and pop 2*DEPTH + 1 words with alternating stalls -> output order matches input order exactly.
REQ-037 Reset mid-operation: count = 2 and rst = 0 coincident with push and flush -> next cycle count = 0, freeze = 0 and out_valid = 0.
